// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
//   APB3 completer backing a bank of NUM_REGS read/write registers.
//   Features: programmable wait states, PSLVERR on bad accesses
//   (out-of-range index, or a write to a read-only register), and
//   per-register read-only protection through RO_MASK.
//
//   Optional feature macro: APB_PSTRB_EN
//     defined   -> PSTRB port exists; writes update only strobed byte lanes
//     undefined -> no PSTRB port; writes update the full word
//
// Ports:
//   pclk         in   bus clock, all state on the rising edge
//   prst         in   asynchronous active-high reset
//   PSEL         in   select
//   PENABLE      in   access phase
//   PWRITE       in   1 = write, 0 = read
//   PADDR        in   byte address [ADDR_WIDTH]
//   PWDATA       in   write data [DATA_WIDTH]
//   PSTRB        in   byte strobes [DATA_WIDTH/8] (APB_PSTRB_EN only)
//   PREADY       out  transfer complete (registered)
//   PRDATA       out  read data (registered, holds outside reads)
//   PSLVERR      out  error, meaningful only while PREADY = 1
//   dbg_state_o  out  current FSM state (0 = IDLE, 1 = WAIT, 2 = DONE)
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0),
// followed by access cycles with PSEL=1, PENABLE=1. The transfer completes
// on the rising edge where PSEL, PENABLE and PREADY are all 1; PRDATA and
// PSLVERR are valid during that cycle. Dropping PSEL during wait states
// abandons the transfer without a register write.
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] RO_MASK     = 32'h0
) (
    input  logic                    pclk,
    input  logic                    prst,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR,
    output logic [1:0]              dbg_state_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [3:0] WAIT_LAST =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    // Address decode of the current bus address (used in the setup cycle)
    logic [ADDR_WIDTH-1:0]   addr_idx;
    logic                    setup;
    logic                    idx_oob;
    logic                    ro_hit;
    logic                    bad;
    logic                    err_next;
    logic                    wr_en;

    always_comb begin
        addr_idx = PADDR >> OFF;
        setup    = PSEL && !PENABLE;
        idx_oob  = (addr_idx >= NUM_REGS_A);
        ro_hit   = RO_MASK[addr_idx[4:0]];
        bad      = idx_oob || (PWRITE && ro_hit);
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and wait counter
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and transfer context (all registered below)
    // -----------------------------------------------------------------------
    always_comb begin
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        prdata_d = prdata_q;

        if (state_q == S_IDLE && setup) begin
            idx_d   = addr_idx[IDX_W-1:0];
            write_d = PWRITE;
            err_d   = bad;
            if (!PWRITE) begin
                prdata_d = bad ? '0 : regs_q[addr_idx[IDX_W-1:0]];
            end
        end

        // With no wait states the error is latched on the same edge that
        // enters DONE, so take it from the live decode in that case.
        err_next  = (state_q == S_IDLE) ? bad : err_q;
        pready_d  = (state_d == S_DONE);
        pslverr_d = (state_d == S_DONE) && err_next;
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Register bank. The write lands on the completing edge of a good write.
    // -----------------------------------------------------------------------
    assign wr_en = (state_q == S_DONE) && PSEL && PENABLE && PWRITE &&
                   write_q && !err_q;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
`ifdef APB_PSTRB_EN
            for (int b = 0; b < BYTES; b++) begin
                if (PSTRB[b]) begin
                    regs_q[idx_q][b*8 +: 8] <= PWDATA[b*8 +: 8];
                end
            end
`else
            regs_q[idx_q] <= PWDATA;
`endif
        end
    end

    assign PREADY      = pready_q;
    assign PSLVERR     = pslverr_q;
    assign PRDATA      = prdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_slave
//   Three instances share one APB bus (separate PSEL per instance):
//     u_dut0 : WAIT_CYCLES=0, RO_MASK=0
//     u_dut3 : WAIT_CYCLES=3, RO_MASK=0
//     u_dutr : WAIT_CYCLES=0, RO_MASK=32'h4 (register 2 read-only)
// ---------------------------------------------------------------------------
module tb_apb_regfile_slave;

  logic              pclk = 1'b0;
  logic              prst;
  logic [2:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       paddr;
  logic [31:0]       pwdata;
`ifdef APB_PSTRB_EN
  logic [3:0]        pstrb;
`endif
  logic [2:0]        pready;
  logic [2:0]        pslverr;
  logic [2:0][31:0]  prdata;
  logic [2:0][1:0]   dbg;

  int n_chk = 0;
  int n_err = 0;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  always #5 pclk = ~pclk;

  // -------------------------------------------------------------------------
  // DUTs
  // -------------------------------------------------------------------------
  apb_regfile_slave #(.WAIT_CYCLES(0), .RO_MASK(32'h0)) u_dut0 (
    .pclk        (pclk),
    .prst        (prst),
    .PSEL        (psel[0]),
    .PENABLE     (penable),
    .PWRITE      (pwrite),
    .PADDR       (paddr),
    .PWDATA      (pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB       (pstrb),
`endif
    .PREADY      (pready[0]),
    .PRDATA      (prdata[0]),
    .PSLVERR     (pslverr[0]),
    .dbg_state_o (dbg[0])
  );

  apb_regfile_slave #(.WAIT_CYCLES(3), .RO_MASK(32'h0)) u_dut3 (
    .pclk        (pclk),
    .prst        (prst),
    .PSEL        (psel[1]),
    .PENABLE     (penable),
    .PWRITE      (pwrite),
    .PADDR       (paddr),
    .PWDATA      (pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB       (pstrb),
`endif
    .PREADY      (pready[1]),
    .PRDATA      (prdata[1]),
    .PSLVERR     (pslverr[1]),
    .dbg_state_o (dbg[1])
  );

  apb_regfile_slave #(.WAIT_CYCLES(0), .RO_MASK(32'h4)) u_dutr (
    .pclk        (pclk),
    .prst        (prst),
    .PSEL        (psel[2]),
    .PENABLE     (penable),
    .PWRITE      (pwrite),
    .PADDR       (paddr),
    .PWDATA      (pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB       (pstrb),
`endif
    .PREADY      (pready[2]),
    .PRDATA      (prdata[2]),
    .PSLVERR     (pslverr[2]),
    .dbg_state_o (dbg[2])
  );

  // -------------------------------------------------------------------------
  // Scoreboard check
  // -------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic bus_idle();
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  // One APB transfer on instance 'which'. Returns after PREADY is seen; the
  // completing edge is the next rising edge, consumed by the caller's next
  // driver call (which makes consecutive calls back-to-back).
  task automatic apb_xfer(input int which, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int waits);
    @(posedge pclk); #1;
    psel    = 3'(1 << which);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits   = 0;
    while (pready[which] !== 1'b1 && waits < 40) begin
      waits++;
      @(posedge pclk); #1;
    end
    if (waits >= 40) chk("timeout_pready", 32'(waits), 32'd0);
    rdata = prdata[which];
    err   = pslverr[which];
  endtask

  task automatic do_write(input string tag, input int which, input logic [31:0] addr,
                          input logic [31:0] data, input logic exp_err, input int exp_waits);
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(which, 1'b1, addr, data, rd, e, w);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
  endtask

  task automatic do_read(input string tag, input int which, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_waits);
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(which, 1'b0, addr, 32'h0, rd, e, w);
    chk({tag, "_data"}, rd, exp_data);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
  endtask

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  initial begin
    prst    = 1'b1;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
`ifdef APB_PSTRB_EN
    pstrb   = 4'hF;
`endif
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_pready", {29'd0, pready}, 32'd0);
    chk("rst_pslverr", {29'd0, pslverr}, 32'd0);
    chk("rst_prdata0", prdata[0], 32'h0);
    chk("rst_state3", {30'd0, dbg[1]}, 32'd0);
    prst = 1'b0;

    // All registers read zero after reset, no wait states
    for (int i = 0; i < 16; i++) begin
      do_read($sformatf("rst_read_r%0d", i), 0, 32'(i * 4), 32'h0, 1'b0, 0);
    end

    // Write then back-to-back reads; low address bits ignored
    do_write("wr_08", 0, 32'h08, 32'hDEADBEEF, 1'b0, 0);
    do_read("rd_08", 0, 32'h08, 32'hDEADBEEF, 1'b0, 0);
    do_read("rd_0b", 0, 32'h0B, 32'hDEADBEEF, 1'b0, 0);
    do_write("wr_0c", 0, 32'h0C, 32'h12345678, 1'b0, 0);
    bus_idle();
    chk("prdata_hold_after_wr", prdata[0], 32'hDEADBEEF);
    do_read("rd_0c", 0, 32'h0C, 32'h12345678, 1'b0, 0);

    // Out-of-range index
    do_read("rd_oob", 0, 32'h40, 32'h0, 1'b1, 0);
    do_write("wr_oob", 0, 32'h40, 32'hFFFFFFFF, 1'b1, 0);
    do_read("rd_0c_after_oob", 0, 32'h0C, 32'h12345678, 1'b0, 0);

    // Read-only register 2
    do_write("wr_ro2", 2, 32'h08, 32'hCAFEF00D, 1'b1, 0);
    do_read("rd_ro2", 2, 32'h08, 32'h0, 1'b0, 0);
    do_write("wr_rw3", 2, 32'h0C, 32'h00000055, 1'b0, 0);
    do_read("rd_rw3", 2, 32'h0C, 32'h00000055, 1'b0, 0);

    // Wait states
    do_write("wr_w3_04", 1, 32'h04, 32'hA5A50F0F, 1'b0, 3);
    do_read("rd_w3_04", 1, 32'h04, 32'hA5A50F0F, 1'b0, 3);
    bus_idle();

    // PENABLE without setup is ignored
    @(posedge pclk); #1;
    psel    = 3'b111;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      chk($sformatf("no_setup_pready_c%0d", i), {29'd0, pready}, 32'd0);
    end
    bus_idle();

    // PSEL dropped during wait states aborts with no write
    @(posedge pclk); #1;
    psel    = 3'b010;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'h00000077;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("abort_in_wait", {30'd0, dbg[1]}, 32'd1);
    chk("abort_pready_low", {31'd0, pready[1]}, 32'd0);
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_idle", {30'd0, dbg[1]}, 32'd0);
    chk("abort_no_pready", {31'd0, pready[1]}, 32'd0);
    do_read("rd_aborted_10", 1, 32'h10, 32'h0, 1'b0, 3);
    bus_idle();

    // Reset in the middle of a wait-state write
    @(posedge pclk); #1;
    psel    = 3'b010;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0C;
    pwdata  = 32'h99999999;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b1;
    #1;
    chk("midrst_pready", {31'd0, pready[1]}, 32'd0);
    chk("midrst_state", {30'd0, dbg[1]}, 32'd0);
    chk("midrst_prdata0", prdata[0], 32'h0);
    @(posedge pclk); #1;
    prst    = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    do_read("rd_midrst_0c", 1, 32'h0C, 32'h0, 1'b0, 3);
    do_read("rd_midrst_04", 1, 32'h04, 32'h0, 1'b0, 3);
    do_read("rd_midrst_d0_08", 0, 32'h08, 32'h0, 1'b0, 0);

`ifdef APB_PSTRB_EN
    // Byte-lane strobes
    pstrb = 4'hF;
    do_write("strb_pre", 0, 32'h14, 32'h11223344, 1'b0, 0);
    pstrb = 4'b0101;
    do_write("strb_0101", 0, 32'h14, 32'hAABBCCDD, 1'b0, 0);
    pstrb = 4'hF;
    do_read("rd_strb_0101", 0, 32'h14, 32'h11BB33DD, 1'b0, 0);
    pstrb = 4'b0000;
    do_write("strb_0000", 0, 32'h14, 32'hFFFFFFFF, 1'b0, 0);
    pstrb = 4'hF;
    do_read("rd_strb_0000", 0, 32'h14, 32'h11BB33DD, 1'b0, 0);
`endif

    bus_idle();
    repeat (2) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time limit so the run always reaches its summary line
  initial begin
    #200000;
    n_chk++;
    n_err++;
    $display("FAIL global_timeout: got=running exp=finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- Parametrised APB3 completer. Successor to the fixed no-wait APB slave.
- Backs a bank of NUM_REGS read/write registers of DATA_WIDTH bits.
- Adds programmable wait states, PSLVERR on bad accesses, and per-register read-only protection.
- Sits on the peripheral bus as the standard register-target for UVM bench and SoC peripherals.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
- NUM_REGS, 16, number of registers; 1..32.
- WAIT_CYCLES, 0, PREADY-low cycles inserted in each access phase; 0..15.
- RO_MASK, 32'h0, bit i=1 makes register i read-only.

Ports:
- pclk  in  1  bus clock, all state on rising edge.
- prst  in  1  asynchronous, active-high reset.
- PSEL  in  1  select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte strobes; present only with APB_PSTRB_EN.
- PREADY  out  1  transfer complete.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERR  out  1  error, valid only while PREADY=1.

Behaviour:
- Reset: on prst=1, asynchronously and immediately:
  - state=IDLE, wait counter=0, PREADY=0, PSLVERR=0, PRDATA=0, all registers=0.
  - A reset mid-transfer aborts the transfer with no write.
- Address decode:
  - BYTES=DATA_WIDTH/8. Register index = PADDR >> log2(BYTES); low byte-offset bits are ignored.
  - Bad access: index >= NUM_REGS, or a write to an index with RO_MASK set.
- FSM, with all outputs driven from flops:
  - IDLE: PSEL=1 and PENABLE=0 is the setup cycle. Latch index, PWRITE and the error flag. For a good read, load PRDATA with regs[index]; for a bad read, load 0. Go to WAIT if WAIT_CYCLES>0, else DONE. Otherwise stay in IDLE.
  - WAIT: PREADY=0. Counter increments each cycle. At count WAIT_CYCLES-1, go to DONE with PREADY=1 and PSLVERR=err registered. If PSEL=0, abort to IDLE with no write.
  - DONE: PREADY=1 for exactly one cycle; PSLVERR=err. On this edge, if PSEL, PENABLE and PWRITE are all 1 and there is no error, write regs[index] from PWDATA. Always return to IDLE, clear PREADY/PSLVERR and reset the counter.
- Latency: the access phase lasts WAIT_CYCLES+1 cycles.
- Back-to-back: a setup cycle directly after DONE is accepted from IDLE with no idle gap.
- Read-after-write to the same register returns the new value.
- PRDATA holds its last value outside read transfers; writes do not change it.
- An erroring write leaves all registers unchanged. An erroring read returns PRDATA=0.
- PENABLE=1 seen in IDLE without a preceding setup is ignored and produces no PREADY.

Optional Feature:
- Macro APB_PSTRB_EN.
- Defined:
  - The PSTRB port exists.
  - A write updates only the byte lanes whose strobe is 1.
  - A write with PSTRB all-zero completes with no change and no error.
- Undefined:
  - No PSTRB port.
  - Every write updates the full word.

Test Plan:
- Reset then read all 16 registers (WAIT_CYCLES=0) -> each PREADY on the first access cycle, PRDATA=0, PSLVERR=0.
- Write 32'hDEADBEEF to addr 0x08, then read 0x08 back-to-back -> PRDATA=32'hDEADBEEF, no idle cycle needed between transfers.
- WAIT_CYCLES=3, write then read addr 0x04 -> PREADY low for 3 access cycles and high on the 4th, data matches.
- Read addr 0x40 (index 16, NUM_REGS=16) -> PREADY=1, PSLVERR=1, PRDATA=0. Write to register 2 with RO_MASK=32'h4 -> PSLVERR=1 and register 2 unchanged.
- Assert prst during WAIT of a write to 0x0C -> PREADY=0 immediately, register 0x0C reads back 0 after reset.
- APB_PSTRB_EN: preload 32'h11223344, write 32'hAABBCCDD with PSTRB=4'b0101 -> readback 32'h11BB33DD.
